// File: rtl/pixel_fb_writer_pkg.sv
// Shared types and constants for the double-buffered pixel frame-buffer writer.
package pixel_fb_writer_pkg;

    typedef logic [0:0] fb_state_t;

    localparam fb_state_t ST_WRITING   = 1'b0;
    localparam fb_state_t ST_WAIT_SWAP = 1'b1;

    localparam int FB_ADDR_W = 17;
    localparam int COLOR_W   = 12;

    localparam logic [COLOR_W-1:0] BG_COLOR_DEFAULT = 12'h000;

endpackage

// File: rtl/pixel_fb_writer.sv
// Decimates the screen pixel stream into a scaled back buffer and swaps
// front/back banks on the first display vsync after the frame's last pixel.
module pixel_fb_writer
    import pixel_fb_writer_pkg::*;
#(
    parameter int                 FB_WIDTH    = 320,
    parameter int                 FB_HEIGHT   = 180,
    parameter int                 SCALE_SHIFT = 2,
    parameter logic [COLOR_W-1:0] BG_COLOR    = BG_COLOR_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [10:0]          x_in,
    input  logic [9:0]           y_in,
    input  logic                 block_visible_in,
    input  logic [3:0]           r_in,
    input  logic [3:0]           g_in,
    input  logic [3:0]           b_in,
    input  logic                 rgb_valid_in,
    input  logic                 vsync_in,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [COLOR_W-1:0]   fb_data,
    output logic                 front_bank,
    output logic                 frame_swapped,
    output logic [15:0]          drop_count
);

    localparam logic [10:0] X_MASK = 11'((1 << SCALE_SHIFT) - 1);
    localparam logic [9:0]  Y_MASK = 10'((1 << SCALE_SHIFT) - 1);
    localparam logic [10:0] XS_LIM = 11'(FB_WIDTH);
    localparam logic [9:0]  YS_LIM = 10'(FB_HEIGHT);
    localparam logic [10:0] LAST_X = 11'(FB_WIDTH - 1);
    localparam logic [9:0]  LAST_Y = 10'(FB_HEIGHT - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [10:0] xs;
    logic [9:0]  ys;
    logic        accept;
    logic [15:0] offset;

    logic                 s1_vld_q, s1_vld_d;
    logic [10:0]          s1_xs_q, s1_xs_d;
    logic [9:0]           s1_ys_q, s1_ys_d;
    logic [COLOR_W-1:0]   s1_data_q, s1_data_d;
    logic                 s1_last_q, s1_last_d;
    logic                 fb_we_q, fb_we_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0]   fb_data_q, fb_data_d;
    fb_state_t            state_q, state_d;
    logic                 front_bank_q, front_bank_d;
    logic                 frame_swapped_q, frame_swapped_d;
    logic [15:0]          drop_count_q, drop_count_d;

    assign xs     = x_in >> SCALE_SHIFT;
    assign ys     = y_in >> SCALE_SHIFT;
    assign accept = rgb_valid_in
                 && ((x_in & X_MASK) == 11'd0) && ((y_in & Y_MASK) == 10'd0)
                 && (xs < XS_LIM) && (ys < YS_LIM);
    assign offset = 16'(s1_ys_q) * 16'(FB_WIDTH) + 16'(s1_xs_q);

    always_comb begin
        // Stage 1: decimate, range-check and pick colour.
        s1_vld_d  = accept;
        s1_xs_d   = xs;
        s1_ys_d   = ys;
        s1_data_d = block_visible_in ? {r_in, g_in, b_in} : BG_COLOR;
        s1_last_d = accept && (xs == LAST_X) && (ys == LAST_Y);

        // Stage 2: address into the back bank; in-flight pixels die once waiting.
        fb_we_d   = s1_vld_q && (state_q == ST_WRITING);
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        if (fb_we_d) begin
            fb_addr_d = {~front_bank_q, offset};
            fb_data_d = s1_data_q;
        end

        state_d         = state_q;
        front_bank_d    = front_bank_q;
        frame_swapped_d = 1'b0;
        drop_count_d    = drop_count_q;
        if (state_q == ST_WRITING) begin
            if (s1_vld_q && s1_last_q) begin
                state_d = ST_WAIT_SWAP;
            end
        end else begin
            if (accept) begin
                drop_count_d = sat_inc(drop_count_q);
            end
            if (vsync_in) begin
                state_d         = ST_WRITING;
                front_bank_d    = ~front_bank_q;
                frame_swapped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_vld_q        <= 1'b0;
            s1_xs_q         <= '0;
            s1_ys_q         <= '0;
            s1_data_q       <= '0;
            s1_last_q       <= 1'b0;
            fb_we_q         <= 1'b0;
            fb_addr_q       <= '0;
            fb_data_q       <= '0;
            state_q         <= ST_WRITING;
            front_bank_q    <= 1'b0;
            frame_swapped_q <= 1'b0;
            drop_count_q    <= '0;
        end else begin
            s1_vld_q        <= s1_vld_d;
            s1_xs_q         <= s1_xs_d;
            s1_ys_q         <= s1_ys_d;
            s1_data_q       <= s1_data_d;
            s1_last_q       <= s1_last_d;
            fb_we_q         <= fb_we_d;
            fb_addr_q       <= fb_addr_d;
            fb_data_q       <= fb_data_d;
            state_q         <= state_d;
            front_bank_q    <= front_bank_d;
            frame_swapped_q <= frame_swapped_d;
            drop_count_q    <= drop_count_d;
        end
    end

    assign fb_we         = fb_we_q;
    assign fb_addr       = fb_addr_q;
    assign fb_data       = fb_data_q;
    assign front_bank    = front_bank_q;
    assign frame_swapped = frame_swapped_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer with a write scoreboard and a timing-aware bank/drop model.
module tb_pixel_fb_writer;

    localparam int W = 320;
    localparam int H = 180;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] x_in = '0;
    logic [9:0]  y_in = '0;
    logic        block_visible_in = 1'b0;
    logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
    logic        rgb_valid_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [11:0] fb_data;
    logic        front_bank;
    logic        frame_swapped;
    logic [15:0] drop_count;

    pixel_fb_writer dut (
        .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
        .block_visible_in(block_visible_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .rgb_valid_in(rgb_valid_in), .vsync_in(vsync_in), .fb_we(fb_we),
        .fb_addr(fb_addr), .fb_data(fb_data), .front_bank(front_bank),
        .frame_swapped(frame_swapped), .drop_count(drop_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [16:0] addr;
        logic [11:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t mon_exp;
    int  vectors = 0;
    int  miscompares = 0;
    int  writes = 0;
    int  edges = 0;

    // Model: waiting for swap becomes effective after edge m_wait_edge.
    bit  m_wait = 1'b0;
    int  m_wait_edge = 0;
    bit  m_front = 1'b0;
    int  m_drop = 0;

    always @(posedge clk_in) edges++;

    always @(negedge clk_in) begin
        if (!rst_in && fb_we) begin
            writes++;
            vectors++;
            assert (sb.size() > 0)
            else begin
                miscompares++;
                $error("FAIL unexpected_we observed addr=%h data=%h expected no write", fb_addr, fb_data);
            end
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                vectors++;
                assert ({fb_addr, fb_data} === {mon_exp.addr, mon_exp.data})
                else begin
                    miscompares++;
                    $error("FAIL write observed addr=%h data=%h expected addr=%h data=%h",
                           fb_addr, fb_data, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int x, input int y, input bit vis,
                        input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        int  n, xs, ys;
        bit  acc;
        wr_t e;
        n   = edges + 1;
        xs  = x / 4;
        ys  = y / 4;
        acc = (x % 4 == 0) && (y % 4 == 0) && (xs < W) && (ys < H);
        x_in = 11'(x);
        y_in = 10'(y);
        block_visible_in = vis;
        r_in = r; g_in = g; b_in = b;
        rgb_valid_in = 1'b1;
        if (m_wait) begin
            if (acc && n > m_wait_edge && m_drop < 65535) m_drop++;
        end else if (acc) begin
            e.addr = {~m_front, 16'(ys * W + xs)};
            e.data = vis ? {r, g, b} : 12'h000;
            sb.push_back(e);
            if (xs == W - 1 && ys == H - 1) begin
                m_wait = 1'b1;
                m_wait_edge = n + 1;
            end
        end
        @(negedge clk_in);
    endtask

    task automatic idle();
        rgb_valid_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic vsync(input string tag);
        int m;
        bit swap;
        m = edges + 1;
        swap = m_wait && (m > m_wait_edge);
        vsync_in = 1'b1;
        @(negedge clk_in);
        vsync_in = 1'b0;
        if (swap) begin
            m_front = ~m_front;
            m_wait = 1'b0;
        end
        chk({tag, "_swapped"}, 32'(frame_swapped), 32'(swap));
        chk({tag, "_front"}, 32'(front_bank), 32'(m_front));
    endtask

    task automatic drain();
        int t;
        rgb_valid_in = 1'b0;
        t = 0;
        while (sb.size() > 0 && t < 20) begin
            @(negedge clk_in);
            t++;
        end
        @(negedge clk_in);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int w0;
        repeat (2) @(negedge clk_in);
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        chk("rst_data", 32'(fb_data), 32'd0);
        chk("rst_front", 32'(front_bank), 32'd0);
        chk("rst_swapped", 32'(frame_swapped), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        send(8, 4, 1'b1, 4'hF, 4'h0, 4'hA);
        rgb_valid_in = 1'b0;
        chk("lat1_we", 32'(fb_we), 32'd0);
        idle();
        chk("lat2_we", 32'(fb_we), 32'd1);
        chk("lat2_addr", 32'(fb_addr), 32'h1_0142);
        chk("lat2_data", 32'(fb_data), 32'hF0A);
        idle();
        chk("we_one_cycle", 32'(fb_we), 32'd0);

        send(9, 4, 1'b1, 4'h1, 4'h2, 4'h3);
        send(1280, 0, 1'b1, 4'h1, 4'h2, 4'h3);
        send(0, 720, 1'b1, 4'h1, 4'h2, 4'h3);
        send(0, 0, 1'b0, 4'h5, 4'h5, 4'h5);
        send(1276, 0, 1'b1, 4'h7, 4'h8, 4'h9);
        drain();
        chk("no_drop_range", 32'(drop_count), 32'd0);

        w0 = writes;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                send(x * 4, y * 4, bit'((x ^ y) & 1), 4'(x), 4'(y), 4'(x >> 4));
            end
        end
        drain();
        chk("frame_writes", 32'(writes - w0), 32'd57600);
        chk("front_pre_swap", 32'(front_bank), 32'd0);
        vsync("swap1");
        chk("front_after_swap1", 32'(front_bank), 32'd1);
        idle();
        chk("swapped_pulse_end", 32'(frame_swapped), 32'd0);

        send(8, 4, 1'b1, 4'h1, 4'h2, 4'h3);
        rgb_valid_in = 1'b0;
        idle();
        chk("frame2_bank", 32'(fb_addr[16]), 32'd0);
        send(40, 80, 1'b0, 4'hC, 4'hC, 4'hC);
        drain();

        send(1276, 716, 1'b1, 4'hE, 4'hD, 4'hC);
        rgb_valid_in = 1'b0;
        vsync("coincident");
        drain();
        for (int i = 0; i < 5; i++) send(i * 4, 0, 1'b1, 4'h1, 4'h1, 4'h1);
        send(1280, 0, 1'b1, 4'h1, 4'h1, 4'h1);
        send(1, 0, 1'b1, 4'h1, 4'h1, 4'h1);
        idle();
        chk("drop_model", 32'(drop_count), 32'(m_drop));
        chk("drop_five", 32'(drop_count), 32'd5);
        vsync("swap2");
        chk("front_after_swap2", 32'(front_bank), 32'd0);

        send(12, 8, 1'b1, 4'h3, 4'h6, 4'h9);
        drain();

        send(16, 16, 1'b1, 4'hA, 4'hB, 4'hC);
        rgb_valid_in = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        chk("async_we", 32'(fb_we), 32'd0);
        chk("async_addr", 32'(fb_addr), 32'd0);
        chk("async_data", 32'(fb_data), 32'd0);
        chk("async_drop", 32'(drop_count), 32'd0);
        chk("async_front", 32'(front_bank), 32'd0);
        sb.delete();
        m_wait = 1'b0;
        m_front = 1'b0;
        m_drop = 0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            chk("post_rst_we", 32'(fb_we), 32'd0);
        end

        send(4, 4, 1'b1, 4'h4, 4'h5, 4'h6);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_fb_writer.md
PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FB_WIDTH, 320: stored columns.
- FB_HEIGHT, 180: stored rows.
- SCALE_SHIFT, 2: screen-to-buffer decimation shift.
- BG_COLOR, 12'h000: colour written for non-visible pixels.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_in, input, 1: clock; one clock, all logic on rising edge.
- rst_in, input, 1: reset, asynchronous, active-high.
- x_in, input, 11: screen x of pixel.
- y_in, input, 10: screen y of pixel.
- block_visible_in, input, 1: pixel hit block or saber.
- r_in, input, 4: red nibble.
- g_in, input, 4: green nibble.
- b_in, input, 4: blue nibble.
- rgb_valid_in, input, 1: pixel qualifier, no backpressure.
- vsync_in, input, 1: one-cycle display frame-boundary pulse.
- fb_we, output, 1: frame-buffer write enable.
- fb_addr, output, 17: {back_bank, 16-bit offset}.
- fb_data, output, 12: {r,g,b}.
- front_bank, output, 1: bank the display reads.
- frame_swapped, output, 1: one-cycle pulse on bank swap.
- drop_count, output, 16: saturating count of pixels discarded in WAIT_SWAP.

Function
REQ-003 Accept a pixel on every cycle rgb_valid_in=1; there is no stall path.
REQ-004 Decimation: accept a pixel only if x_in[SCALE_SHIFT-1:0]==0 and y_in[SCALE_SHIFT-1:0]==0.
REQ-005 Scaled coordinates: xs = x_in>>SCALE_SHIFT, ys = y_in>>SCALE_SHIFT.
REQ-006 Out-of-range: discard pixels with xs>=FB_WIDTH or ys>=FB_HEIGHT; no write, no drop count.
REQ-007 Offset = ys*FB_WIDTH + xs, computed as unsigned 16-bit.
REQ-008 Colour: fb_data = {r_in,g_in,b_in} when block_visible_in=1, else BG_COLOR.
REQ-009 Pipeline is exactly 2 stages: stage 1 registers decimate/range/colour; stage 2 registers address and drives fb_we. Latency is 2 cycles from rgb_valid_in to fb_we.
REQ-010 fb_we is high for exactly one cycle per accepted pixel; fb_addr and fb_data are valid only while fb_we=1.
REQ-011 FSM states: WRITING and WAIT_SWAP.
REQ-012 In WRITING, an accepted pixel with xs==FB_WIDTH-1 and ys==FB_HEIGHT-1 is written, then the FSM enters WAIT_SWAP on the edge its fb_we is issued.
REQ-013 In WAIT_SWAP, no writes occur; each would-be-accepted pixel increments drop_count, saturating at 16'hFFFF.
REQ-014 In WAIT_SWAP, vsync_in=1 toggles front_bank, pulses frame_swapped, and returns the FSM to WRITING. back_bank = ~front_bank.
REQ-015 vsync_in is ignored in WRITING, including the cycle the FSM enters WAIT_SWAP; the swap needs a later vsync.
REQ-016 Pixels already in the pipeline when WAIT_SWAP is entered are dropped, not written.
REQ-017 Rows need not arrive in order; only the last-pixel coordinate ends the frame.

Reset
REQ-018 rst_in asserted asynchronously clears: fb_we=0, fb_addr=0, fb_data=0, front_bank=0, frame_swapped=0, drop_count=0, FSM=WRITING, both pipeline valid bits=0.
REQ-019 Reset mid-frame discards in-flight pixels; no partial write is issued after reset release.

Structure
REQ-020 Shared package holds the FSM state typedef, the FB_ADDR_W=17 and COLOR_W=12 constants, and the default BG_COLOR.
REQ-021 The block is a single module with no sub-module; the frame-buffer BRAM is external and instantiated by the parent.

Verification
REQ-022 Valid pixel (x=8, y=4, visible, r=F, g=0, b=A) -> two cycles later fb_we=1, fb_addr={1,16'd322}, fb_data=12'hF0A.
REQ-023 Pixel x=9, y=4 -> no fb_we. Pixel x=1280, y=0 -> no fb_we and drop_count unchanged.
REQ-024 Invisible pixel (x=0, y=0) -> fb_data=12'h000, fb_addr={1,16'd0}.
REQ-025 Full-frame sweep ending at (1276,716) -> 57600 writes; on vsync the next cycle front_bank becomes 1 and frame_swapped pulses; the next frame writes with fb_addr[16]=0.
REQ-026 vsync coincident with last-pixel write -> no swap; 5 accepted pixels in WAIT_SWAP -> drop_count=5; a second vsync -> swap.
REQ-027 rst_in asserted one cycle after a valid pixel -> outputs clear immediately (asynchronously), and no fb_we is issued after release.
